// File: rtl/gamma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gamma_pkg
// Description : Shared types and constants for the gamma cycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
package gamma_pkg;

    // Default spike-time width (gamma period T = 2^LOG_TIME_PERIOD)
    localparam int LOG_TIME_PERIOD = 3;

    // Gamma period length for the default spike-time width
    localparam int T_VAL = 1 << LOG_TIME_PERIOD;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } gamma_state_t;

    // Packed spike time for the default width
    typedef logic [LOG_TIME_PERIOD-1:0] spike_time_t;

endpackage : gamma_pkg
`default_nettype wire

// File: rtl/spike_generation.sv
`default_nettype none
// ============================================================================
// Module      : spike_generation
// Description : Per-channel temporal spike detector. The level output is high
//               once the gamma time has reached the channel's spike time,
//               unless the channel is suppressed.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_generation #(
    parameter int LOG_T = 3
) (
    input  logic             i_should_spike,  // asserted = channel suppressed
    input  logic [LOG_T:0]   i_time_val,
    input  logic [LOG_T-1:0] i_spike_time,
    output logic             o_spike_val
);

    // Unsigned compare against the zero-extended spike time; time T never wraps
    assign o_spike_val = ~i_should_spike & (i_time_val >= {1'b0, i_spike_time});

endmodule : spike_generation
`default_nettype wire

// File: rtl/gamma_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : gamma_cycle_controller
// Description : Sequences one gamma cycle. Accepts a volley of per-channel
//               spike times, steps the shared time counter 0..T-1, converts
//               each channel's level into a single spike pulse via inhibit
//               registers and applies global winner-take-all inhibition.
// Revision    : 1.0 - initial release
// ============================================================================
module gamma_cycle_controller
    import gamma_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int LOG_T = LOG_TIME_PERIOD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_CH*LOG_T-1:0] in_times,
    input  logic [N_CH-1:0]       in_mask,
    input  logic                  step,
    input  logic                  wta_inhibit,
    output logic [LOG_T:0]        time_val,
    output logic [N_CH-1:0]       spikes,
    output logic                  busy,
    output logic                  cycle_done
);

    // Last RUN time value and the end-of-cycle marker T
    localparam logic [LOG_T:0] c_T_LAST = {1'b0, {LOG_T{1'b1}}};
    localparam logic [LOG_T:0] c_T_END  = {1'b1, {LOG_T{1'b0}}};

    gamma_state_t          r_state;
    gamma_state_t          w_state_nxt;
    logic [LOG_T:0]        r_time;
    logic [LOG_T:0]        w_time_nxt;
    logic [N_CH-1:0]       r_inhibit;
    logic [N_CH-1:0]       w_inhibit_nxt;
    logic [N_CH*LOG_T-1:0] r_times;
    logic [N_CH*LOG_T-1:0] w_times_nxt;

    logic [N_CH-1:0]       w_spike_val;
    logic [N_CH-1:0]       w_spikes;
    logic                  w_fire_en;

    // One spike detector per channel
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_spike_gen
            spike_generation #(
                .LOG_T (LOG_T)
            ) u_spike_generation (
                .i_should_spike (r_inhibit[gi]),
                .i_time_val     (r_time),
                .i_spike_time   (r_times[gi*LOG_T +: LOG_T]),
                .o_spike_val    (w_spike_val[gi])
            );
        end
    endgenerate

    // Spikes are only emitted on stepped RUN cycles
    assign w_fire_en = step & (r_state == ST_RUN);
    assign w_spikes  = w_spike_val & {N_CH{w_fire_en}};

    // State, time, inhibit and latched spike-time registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_time    <= '0;
            r_inhibit <= '1;
            r_times   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_time    <= w_time_nxt;
            r_inhibit <= w_inhibit_nxt;
            r_times   <= w_times_nxt;
        end
    end

    // Next-state, time stepping and inhibit update
    always_comb begin
        w_state_nxt   = r_state;
        w_time_nxt    = r_time;
        w_inhibit_nxt = r_inhibit;
        w_times_nxt   = r_times;
        case (r_state)
            ST_IDLE: begin
                w_time_nxt    = '0;
                w_inhibit_nxt = '1;
                if (in_valid) begin
                    w_times_nxt   = in_times;
                    w_inhibit_nxt = ~in_mask;
                    w_state_nxt   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (step) begin
                    // A channel that fired is blocked for the rest of the cycle
                    w_inhibit_nxt = r_inhibit | w_spikes;
                    if (r_time == c_T_LAST) begin
                        w_time_nxt    = c_T_END;
                        w_inhibit_nxt = '1;
                        w_state_nxt   = ST_DONE;
                    end else begin
                        w_time_nxt = r_time + 1'b1;
                    end
                end
                // Lateral inhibition blocks all later spikes; time keeps running
                if (wta_inhibit) begin
                    w_inhibit_nxt = '1;
                end
            end
            ST_DONE: begin
                w_time_nxt    = '0;
                w_inhibit_nxt = '1;
                w_state_nxt   = ST_IDLE;
            end
            default: begin
                w_time_nxt    = '0;
                w_inhibit_nxt = '1;
                w_state_nxt   = ST_IDLE;
            end
        endcase
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign busy       = (r_state == ST_RUN) | (r_state == ST_DONE);
    assign cycle_done = (r_state == ST_DONE);
    assign time_val   = r_time;
    assign spikes     = w_spikes;

endmodule : gamma_cycle_controller
`default_nettype wire

// File: tb/tb_gamma_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_gamma_cycle_controller
// Description : Directed self-checking bench for gamma_cycle_controller
//               (N_CH=4, LOG_T=3, T=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gamma_cycle_controller;

    localparam int N_CH  = 4;
    localparam int LOG_T = 3;

    // Spike times packed {ch3, ch2, ch1, ch0}
    localparam logic [11:0] c_TIMES_A = {3'd5, 3'd7, 3'd0, 3'd3};
    localparam logic [11:0] c_TIMES_M = {3'd5, 3'd0, 3'd0, 3'd3};
    localparam logic [11:0] c_TIMES_B = {3'd4, 3'd2, 3'd6, 3'd1};

    // Expected spikes per time step, nibble t = spikes at time_val t
    localparam logic [31:0] c_EXP_A = 32'h4080_1002;
    localparam logic [31:0] c_EXP_M = 32'h0080_1002;
    localparam logic [31:0] c_EXP_B = 32'h0208_0410;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_times;
    logic [3:0]  in_mask;
    logic        step;
    logic        wta_inhibit;
    logic [3:0]  time_val;
    logic [3:0]  spikes;
    logic        busy;
    logic        cycle_done;

    int n_assert = 0;
    int n_fail   = 0;

    gamma_cycle_controller #(
        .N_CH  (N_CH),
        .LOG_T (LOG_T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_times    (in_times),
        .in_mask     (in_mask),
        .step        (step),
        .wta_inhibit (wta_inhibit),
        .time_val    (time_val),
        .spikes      (spikes),
        .busy        (busy),
        .cycle_done  (cycle_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive step/wta for this cycle, check time and spikes, then advance
    task automatic run_cycle(input logic s, input logic w, input int t, input logic [3:0] exp_spk);
        step        = s;
        wta_inhibit = w;
        #1;
        check($sformatf("time@%0d", t), 32'(time_val), 32'(t));
        check($sformatf("spikes@%0d", t), 32'(spikes), 32'(exp_spk));
        check($sformatf("busy@%0d", t), 32'(busy), 32'd1);
        tick();
        wta_inhibit = 1'b0;
    endtask

    // Present a volley in IDLE and let the edge accept it
    task automatic accept(input logic [11:0] times, input logic [3:0] mask);
        in_valid = 1'b1;
        in_times = times;
        in_mask  = mask;
        #1;
        check("in_ready_accept", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Step times from..7 with step held high
    task automatic run_rest(input logic [31:0] exp_tab, input int from);
        for (int t = from; t < 8; t++) begin
            run_cycle(1'b1, 1'b0, t, exp_tab[t*4 +: 4]);
        end
    endtask

    // DONE cycle followed by a check of the IDLE cycle
    task automatic check_done_idle();
        #1;
        check("done_time", 32'(time_val), 32'd8);
        check("done_pulse", 32'(cycle_done), 32'd1);
        check("done_ready", 32'(in_ready), 32'd0);
        check("done_spikes", 32'(spikes), 32'd0);
        tick();
        #1;
        check("idle_ready", 32'(in_ready), 32'd1);
        check("idle_time", 32'(time_val), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(cycle_done), 32'd0);
    endtask

    initial begin
        #200000;
        $error("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_times    = '0;
        in_mask     = '0;
        step        = 1'b1;
        wta_inhibit = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_time", 32'(time_val), 32'd0);
        check("rst_spikes", 32'(spikes), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(cycle_done), 32'd0);

        // Full volley
        accept(c_TIMES_A, 4'b1111);
        run_rest(c_EXP_A, 0);
        check_done_idle();

        // Masked channel 2 with spike time 0
        accept(c_TIMES_M, 4'b1011);
        run_rest(c_EXP_M, 0);
        check_done_idle();

        // Step stall at time 3
        accept(c_TIMES_A, 4'b1111);
        run_cycle(1'b1, 1'b0, 0, 4'b0010);
        run_cycle(1'b1, 1'b0, 1, 4'b0000);
        run_cycle(1'b1, 1'b0, 2, 4'b0000);
        run_cycle(1'b0, 1'b0, 3, 4'b0000);
        run_cycle(1'b0, 1'b0, 3, 4'b0000);
        run_cycle(1'b0, 1'b0, 3, 4'b0000);
        run_cycle(1'b1, 1'b0, 3, 4'b0001);
        run_rest(c_EXP_A, 4);
        check_done_idle();

        // Winner-take-all at time 3
        accept(c_TIMES_A, 4'b1111);
        run_cycle(1'b1, 1'b0, 0, 4'b0010);
        run_cycle(1'b1, 1'b0, 1, 4'b0000);
        run_cycle(1'b1, 1'b0, 2, 4'b0000);
        run_cycle(1'b1, 1'b1, 3, 4'b0001);
        run_rest(32'h0, 4);
        check_done_idle();

        // Reset at time 4
        accept(c_TIMES_A, 4'b1111);
        run_rest(c_EXP_A, 0);
        check_done_idle();
        accept(c_TIMES_A, 4'b1111);
        for (int t = 0; t < 4; t++) begin
            run_cycle(1'b1, 1'b0, t, c_EXP_A[t*4 +: 4]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_time", 32'(time_val), 32'd0);
        check("mid_rst_spikes", 32'(spikes), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_done", 32'(cycle_done), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        accept(c_TIMES_B, 4'b1111);
        run_rest(c_EXP_B, 0);
        check_done_idle();

        // Volley B held on in_valid during RUN of A: ignored, then accepted back-to-back
        accept(c_TIMES_A, 4'b1111);
        in_valid = 1'b1;
        in_times = c_TIMES_B;
        run_rest(c_EXP_A, 0);
        check_done_idle();
        tick();
        in_valid = 1'b0;
        run_rest(c_EXP_B, 0);
        check_done_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_gamma_cycle_controller
`default_nettype wire

// File: doc/gamma_cycle_controller.md
# gamma_cycle_controller

Sequences one gamma cycle of temporally coded input spikes for the clocked STDP datapath. Accepts a volley of per-channel spike times through a valid/ready handshake and steps the shared time counter from 0 to T-1, where T = 2^LOG_T. It drives one `spike_generation` instance per channel. Each channel's level output becomes a single-cycle spike pulse through per-channel inhibit registers, and a global winner-take-all inhibit is applied. It sits between the input encoder and the column/neuron array.

## Interface
- `N_CH`, default 8: number of input channels.
- `LOG_T`, default `` `log_time_period ``: spike time width. Time period T = 2^LOG_T.
- `clk`, input, 1: single clock. All state changes on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: a new volley is present on `in_times`/`in_mask`.
- `in_ready`, output, 1: controller can accept a volley. High only in IDLE.
- `in_times`, input, N_CH*LOG_T: channel i spike time in bits [i*LOG_T +: LOG_T].
- `in_mask`, input, N_CH: 1 means channel participates. 0 means the channel never spikes this cycle.
- `step`, input, 1: time-step enable. Time advances and spikes are emitted only on `step`.
- `wta_inhibit`, input, 1: global lateral inhibition from the neuron array.
- `time_val`, output, LOG_T+1: current gamma time. Value T marks end of cycle.
- `spikes`, output, N_CH: one-cycle spike pulses.
- `busy`, output, 1: high in RUN or DONE.
- `cycle_done`, output, 1: one-cycle pulse in DONE.

## Operation
- States: IDLE, RUN, DONE. The state type is a shared enum.
- IDLE:
  - `in_ready`=1, `time_val`=0, all inhibit bits = 1, `spikes`=0.
  - When `in_valid`&&`in_ready`: latch `in_times` into `times_q`, set `inhibit_q` = ~`in_mask`, set `time_val`=0, go to RUN.
- RUN, per channel i:
  - `spike_generation` receives `should_spike`=`inhibit_q[i]`, `time_val`, and `times_q[i]`.
  - `spikes[i]` = `spike_val[i]` & `step` & (state==RUN).
- RUN, on a cycle with `step`=1:
  - `inhibit_q[i]` is set for every i with `spikes[i]`=1.
  - `time_val` increments.
  - If `time_val` was T-1: set `time_val`=T, set all inhibit bits, go to DONE.
- RUN, on a cycle with `step`=0: no state change, `spikes`=0.
- `wta_inhibit`=1 in RUN:
  - Spikes in the same cycle are still emitted, so simultaneous winners are allowed.
  - All `inhibit_q` bits are set on the next edge.
  - Time keeps stepping to T. The gamma period is fixed; there is no early termination.
- DONE: lasts one cycle. `cycle_done`=1, `in_ready`=0. Next state IDLE with `time_val`=0.
- `in_valid` outside IDLE is ignored. The volley is not captured.
- Each unmasked, uninhibited channel emits exactly one spike per cycle: at the first stepped cycle where `time_val` >= spike time. A channel with spike time 0 fires on the first stepped RUN cycle.
- Comparisons are unsigned. `time_val` is one bit wider than a spike time, so the value T never wraps.

## Timing
- Reset values:
  - state IDLE, `time_val`=0, `inhibit_q`=all 1, `times_q`=0.
  - `spikes`=0, `busy`=0, `cycle_done`=0, `in_ready`=1 from the cycle after `rst` is sampled high.
- Reset mid-RUN or mid-DONE: the next cycle is IDLE with the reset values above. No `cycle_done` is emitted.
- Handshake accepted at edge k: RUN and `time_val`=0 visible in cycle k+1. The earliest spike is in cycle k+1, if `step`=1.
- With `step` held high, the cycle is 1 accept edge + T RUN cycles + 1 DONE cycle + return to IDLE. The next accept is possible T+2 cycles after the previous one.
- `spikes` is combinational from registered state plus `step`. All other outputs are registered or decoded from state.

## Structure
- `log_time_period` comes from `internal_defines.vh`.
- Package `gamma_pkg` holds:
  - the state enum (IDLE/RUN/DONE);
  - `T_VAL` = 1 << LOG_T;
  - the packed spike-time type.
- Sub-module: N_CH instances of the existing `spike_generation`, built with a generate loop. No other hierarchy.

## Test plan
All scenarios use N_CH=4, LOG_T=3 (T=8).
- **Full volley:** times {ch0=3, ch1=0, ch2=7, ch3=5}, mask 1111, `step`=1 always. Expect:
  - `spikes`=0010 at `time_val`=0, 0001 at 3, 1000 at 5, 0100 at 7, each exactly one cycle;
  - `time_val`=8 with `cycle_done`=1 one cycle later, then IDLE.
- **Masked channel:** mask 1011 with ch2 time=0. Expect ch2 never spikes; the other channels behave as in the full-volley case.
- **Step stall:** `step` low for 3 cycles while `time_val`=3. Expect:
  - `time_val` holds at 3 and `spikes`=0 during the stall;
  - ch0 spikes on the first cycle `step` returns high;
  - total cycle length is 3 cycles longer.
- **Winner-take-all:** `wta_inhibit`=1 in the `time_val`=3 cycle. Expect:
  - ch0 spikes at 3, and ch1 spiked earlier at 0;
  - ch3 and ch2 never spike;
  - `time_val` still reaches 8 and `cycle_done` fires.
- **Reset mid-RUN:** `rst`=1 at `time_val`=4. Expect next cycle IDLE: `time_val`=0, `spikes`=0, `in_ready`=1, no `cycle_done`. A fresh volley is then accepted normally.
- **Ignored and back-to-back volleys:**
  - `in_valid` held high throughout RUN: volley not captured.
  - After DONE: accepted in the IDLE cycle, new RUN starts at `time_val`=0 with the new times.
